csa_pipe_add: RTL and testbench

CSA_PIPE_ADD -- requirements
Module: csa_pipe_add

---
 rtl/csa_pkg.sv | 24 ++
 rtl/csa_blk.sv | 43 ++++
 rtl/csa_pipe_add.sv | 176 +++++++++++++++++
 tb/tb_csa_pipe_add.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
// Module : csa_pkg
// Brief  : Default sizing constants and level-offset helpers for csa_pipe_add.
// Rev    : 1.0  initial release
// ============================================================================
package csa_pkg;

    localparam int CSA_WIDTH = 32;
    localparam int CSA_BLK   = 4;
    localparam int CSA_BPS   = 4;

    // Operand level L keeps only bits [WIDTH-1 : L*SW]; levels are packed back to back.
    function automatic int csa_opnd_off(input int lvl, input int width, input int sw);
        return lvl * width - (sw * lvl * (lvl - 1)) / 2;
    endfunction

    // Sum level L (L >= 1) keeps bits [L*SW-1 : 0]; levels are packed back to back.
    function automatic int csa_sum_off(input int lvl, input int sw);
        return (sw * lvl * (lvl - 1)) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_blk.sv
`default_nettype none
// ============================================================================
// Module : csa_blk
// Brief  : BLK-bit carry-select block: two ripple sums (carry 0 / carry 1),
//          the incoming carry picks the sum bits and the block carry-out.
// Rev    : 1.0  initial release
// ============================================================================
module csa_blk
    import csa_pkg::*;
#(
    parameter int BLK = CSA_BLK
) (
    input  logic [BLK-1:0] i_a,
    input  logic [BLK-1:0] i_b,
    input  logic           i_cin,
    output logic [BLK-1:0] o_sum,
    output logic           o_cout
);

    logic [BLK-1:0] w_s0;
    logic [BLK-1:0] w_s1;
    logic [BLK:0]   w_c0;
    logic [BLK:0]   w_c1;

    always_comb begin
        w_s0    = '0;
        w_s1    = '0;
        w_c0    = '0;
        w_c1    = '0;
        w_c1[0] = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            w_s0[i]   = i_a[i] ^ i_b[i] ^ w_c0[i];
            w_c0[i+1] = (i_a[i] & i_b[i]) | (w_c0[i] & (i_a[i] ^ i_b[i]));
            w_s1[i]   = i_a[i] ^ i_b[i] ^ w_c1[i];
            w_c1[i+1] = (i_a[i] & i_b[i]) | (w_c1[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_sum  = i_cin ? w_s1 : w_s0;
    assign o_cout = i_cin ? w_c1[BLK] : w_c0[BLK];

endmodule
`default_nettype wire

// File: rtl/csa_pipe_add.sv
`default_nettype none
// ============================================================================
// Module : csa_pipe_add
// Brief  : Pipelined carry-select adder, WIDTH/(BLK*BPS) stages, valid/ready
//          handshake with a global stall. Define CSA_PIPE_OVF_EN to add ovf.
// Rev    : 1.0  initial release
// ============================================================================
module csa_pipe_add
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int BLK   = CSA_BLK,
    parameter int BPS   = CSA_BPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
`ifdef CSA_PIPE_OVF_EN
    output logic             ovf,
`endif
    input  logic             out_ready
);

    localparam int SW   = BLK * BPS;
    localparam int NSTG = (SW > 0) ? (WIDTH / SW) : 1;
    localparam int OTOT = csa_opnd_off(NSTG, WIDTH, SW);
    localparam int STOT = csa_sum_off(NSTG + 1, SW);

    if ((BLK < 1) || ((WIDTH % ((SW > 0) ? SW : 1)) != 0)) begin : g_cfg_err
        $error("csa_pipe_add: WIDTH must be a multiple of BLK*BPS and BLK must be >= 1");
    end

    logic            w_en;
    logic [NSTG:0]   w_v;
    logic [NSTG:0]   w_c;
    logic [OTOT-1:0] w_a;
    logic [OTOT-1:0] w_b;
    logic [STOT-1:0] w_s;
`ifdef CSA_PIPE_OVF_EN
    logic            w_ovf_nxt;
    logic            r_ovf;
`endif

    assign w_en     = out_ready | ~w_v[NSTG];
    assign in_ready = w_en;

    // Level 0 captures the operands on the accepting edge.
    logic             r_v0;
    logic             r_c0;
    logic [WIDTH-1:0] r_a0;
    logic [WIDTH-1:0] r_b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0 <= 1'b0;
            r_c0 <= 1'b0;
            r_a0 <= '0;
            r_b0 <= '0;
        end else if (w_en) begin
            r_v0 <= in_valid;
            r_c0 <= cin;
            r_a0 <= a;
            r_b0 <= b;
        end
    end

    assign w_v[0]         = r_v0;
    assign w_c[0]         = r_c0;
    assign w_a[WIDTH-1:0] = r_a0;
    assign w_b[WIDTH-1:0] = r_b0;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int OOFF = csa_opnd_off(k, WIDTH, SW);
        localparam int SOFF = csa_sum_off(k + 1, SW);

        logic [SW-1:0]         w_sa;
        logic [SW-1:0]         w_sb;
        logic [SW-1:0]         w_ss;
        logic [BPS:0]          w_bc;
        logic [(k+1)*SW-1:0]   w_snext;
        logic [(k+1)*SW-1:0]   r_s;
        logic                  r_v;
        logic                  r_c;

        assign w_sa    = w_a[OOFF +: SW];
        assign w_sb    = w_b[OOFF +: SW];
        assign w_bc[0] = w_c[k];

        for (genvar j = 0; j < BPS; j++) begin : g_blk
            csa_blk #(
                .BLK    (BLK)
            ) u_blk (
                .i_a    (w_sa[j*BLK +: BLK]),
                .i_b    (w_sb[j*BLK +: BLK]),
                .i_cin  (w_bc[j]),
                .o_sum  (w_ss[j*BLK +: BLK]),
                .o_cout (w_bc[j+1])
            );
        end

        if (k == 0) begin : g_s_lsb
            assign w_snext = w_ss;
        end else begin : g_s_acc
            localparam int PSOFF = csa_sum_off(k, SW);
            assign w_snext = {w_ss, w_s[PSOFF +: k*SW]};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_en) begin
                r_v <= w_v[k];
                r_c <= w_bc[BPS];
                r_s <= w_snext;
            end
        end

        assign w_v[k+1]                 = r_v;
        assign w_c[k+1]                 = r_c;
        assign w_s[SOFF +: (k+1)*SW]    = r_s;

        // Unresolved operand bits ride along to the next stage.
        if (k < NSTG - 1) begin : g_opnd
            localparam int ONW  = WIDTH - (k + 1) * SW;
            localparam int NOFF = csa_opnd_off(k + 1, WIDTH, SW);
            logic [ONW-1:0] r_a;
            logic [ONW-1:0] r_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_a[OOFF+SW +: ONW];
                    r_b <= w_b[OOFF+SW +: ONW];
                end
            end

            assign w_a[NOFF +: ONW] = r_a;
            assign w_b[NOFF +: ONW] = r_b;
        end

`ifdef CSA_PIPE_OVF_EN
        if (k == NSTG - 1) begin : g_ovf
            assign w_ovf_nxt = (w_sa[SW-1] ^ w_sb[SW-1] ^ w_ss[SW-1]) ^ w_bc[BPS];
        end
`endif
    end

`ifdef CSA_PIPE_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign ovf = r_ovf;
`endif

    assign sum       = w_s[csa_sum_off(NSTG, SW) +: WIDTH];
    assign cout      = w_c[NSTG];
    assign out_valid = w_v[NSTG];

endmodule
`default_nettype wire

// File: tb/tb_csa_pipe_add.sv
`default_nettype none
// ============================================================================
// Module : tb_csa_pipe_add
// Brief  : Scoreboard bench for csa_pipe_add (32-bit default and 64/8/2 build).
// Rev    : 1.0  initial release
// ============================================================================
module tb_csa_pipe_add;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] a, b, sum;
    logic        cin, in_valid, in_ready, cout, out_valid, out_ready;
    logic [63:0] a64, b64, sum64;
    logic        cin64, iv64, ir64, cout64, ov64, or64;
`ifdef CSA_PIPE_OVF_EN
    logic        ovf, ovf64;
    logic        qo32[$];
    logic        qo64[$];
`endif

    csa_pipe_add u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid),
`ifdef CSA_PIPE_OVF_EN
        .ovf       (ovf),
`endif
        .out_ready (out_ready)
    );

    csa_pipe_add #(.WIDTH(64), .BLK(8), .BPS(2)) u_dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a64),
        .b         (b64),
        .cin       (cin64),
        .in_valid  (iv64),
        .in_ready  (ir64),
        .sum       (sum64),
        .cout      (cout64),
        .out_valid (ov64),
`ifdef CSA_PIPE_OVF_EN
        .ovf       (ovf64),
`endif
        .out_ready (or64)
    );

    int          checks = 0;
    int          errors = 0;
    logic [32:0] q32[$];
    logic [64:0] q64[$];

    function automatic logic sovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    // Drive one cycle: report what the DUT presents/consumes and log accepted operands.
    task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic ic, input logic ordy,
                        output logic took, output logic [32:0] res, output logic rovf);
        logic [32:0] r;
        in_valid = iv; a = ia; b = ib; cin = ic; out_ready = ordy;
        #1;
        took = out_valid && out_ready;
        res  = {cout, sum};
        rovf = 1'b0;
`ifdef CSA_PIPE_OVF_EN
        rovf = ovf;
`endif
        if (in_valid && in_ready) begin
            r = {1'b0, ia} + {1'b0, ib} + {32'd0, ic};
            q32.push_back(r);
`ifdef CSA_PIPE_OVF_EN
            qo32.push_back(sovf(ia[31], ib[31], r[31]));
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step64(input logic iv, input logic [63:0] ia, input logic [63:0] ib,
                          input logic ic, input logic ordy,
                          output logic took, output logic [64:0] res, output logic rovf);
        logic [64:0] r;
        iv64 = iv; a64 = ia; b64 = ib; cin64 = ic; or64 = ordy;
        #1;
        took = ov64 && or64;
        res  = {cout64, sum64};
        rovf = 1'b0;
`ifdef CSA_PIPE_OVF_EN
        rovf = ovf64;
`endif
        if (iv64 && ir64) begin
            r = {1'b0, ia} + {1'b0, ib} + {64'd0, ic};
            q64.push_back(r);
`ifdef CSA_PIPE_OVF_EN
            qo64.push_back(sovf(ia[63], ib[63], r[63]));
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; a = '0; b = '0; cin = 0; out_ready = 0;
        iv64 = 0; a64 = '0; b64 = '0; cin64 = 0; or64 = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (sum !== 32'd0)      begin errors++; $display("FAIL rst_sum: got %h expected 0", sum); end
        checks++; if (cout !== 1'b0)      begin errors++; $display("FAIL rst_cout: got %b expected 0", cout); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
`ifdef CSA_PIPE_OVF_EN
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL post_rst: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_single(input string nm, input logic [31:0] ia, input logic [31:0] ib,
                               input logic ic, input logic [31:0] xs, input logic xc, input logic xo);
        logic        took, ro;
        logic [32:0] res, exp;
        int          lat;
        step(1'b1, ia, ib, ic, 1'b1, took, res, ro);
        lat = 0;
        while (!out_valid && lat < 8) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, took, res, ro);
            lat++;
        end
        checks++; if (lat !== 2) begin errors++; $display("FAIL %s_latency: got %0d expected 2", nm, lat); end
        checks++; if (sum !== xs) begin errors++; $display("FAIL %s_sum: got %h expected %h", nm, sum, xs); end
        checks++; if (cout !== xc) begin errors++; $display("FAIL %s_cout: got %b expected %b", nm, cout, xc); end
`ifdef CSA_PIPE_OVF_EN
        checks++; if (ovf !== xo) begin errors++; $display("FAIL %s_ovf: got %b expected %b", nm, ovf, xo); end
        if (qo32.size() > 0) void'(qo32.pop_front());
`else
        if (xo) ro = 1'b0;
`endif
        exp = (q32.size() > 0) ? q32.pop_front() : 33'h0;
        step(1'b0, '0, '0, 1'b0, 1'b1, took, res, ro);
        checks++; if (!took || res !== exp) begin
            errors++; $display("FAIL %s_model: got took=%b %h expected %h", nm, took, res, exp);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_dup: got out_valid=%b expected 0", nm, out_valid); end
    endtask

    task automatic test_back_to_back();
        logic        took, ro;
        logic [32:0] res, exp;
        int          first, last, n;
        first = -1; last = -1; n = 0;
        for (int i = 0; i < 14; i++) begin
            step(i < 8, $urandom, (i == 3) ? 32'hFFFF_FFFF : $urandom, i[0], 1'b1, took, res, ro);
            if (took) begin
                if (first < 0) first = i;
                last = i; n++;
                exp = (q32.size() > 0) ? q32.pop_front() : 33'h0;
                checks++; if (res !== exp) begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", n, res, exp); end
`ifdef CSA_PIPE_OVF_EN
                if (qo32.size() > 0) begin
                    checks++; if (ro !== qo32[0]) begin errors++; $display("FAIL b2b_ovf: got %b expected %b", ro, qo32[0]); end
                    void'(qo32.pop_front());
                end
`endif
            end
        end
        checks++; if (n !== 8 || (last - first + 1) !== 8) begin
            errors++; $display("FAIL b2b_throughput: got %0d results over %0d cycles expected 8 over 8", n, last - first + 1);
        end
    endtask

    task automatic test_stall();
        logic        took, ro;
        logic [32:0] res, exp;
        int          cyc;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, $urandom, $urandom, 1'b1, 1'b1, took, res, ro);
            if (took) begin
                exp = q32.pop_front();
`ifdef CSA_PIPE_OVF_EN
                void'(qo32.pop_front());
`endif
                checks++; if (res !== exp) begin errors++; $display("FAIL stall_pre: got %h expected %h", res, exp); end
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, $urandom, $urandom, 1'b0, 1'b0, took, res, ro);
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || q32.size() == 0 || {cout, sum} !== q32[0]) begin
                errors++; $display("FAIL stall_hold[%0d]: got rdy=%b vld=%b %h expected 0/1 %h",
                                   i, in_ready, out_valid, {cout, sum}, (q32.size() > 0) ? q32[0] : 33'h0);
            end
        end
        cyc = 0;
        while (q32.size() > 0 && cyc < 12) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, took, res, ro);
            if (took) begin
                exp = q32.pop_front();
                checks++; if (res !== exp) begin errors++; $display("FAIL stall_resume: got %h expected %h", res, exp); end
`ifdef CSA_PIPE_OVF_EN
                checks++; if (ro !== qo32[0]) begin errors++; $display("FAIL stall_ovf: got %b expected %b", ro, qo32[0]); end
                void'(qo32.pop_front());
`endif
            end
            cyc++;
        end
        checks++; if (q32.size() !== 0) begin errors++; $display("FAIL stall_lost: got %0d pending expected 0", q32.size()); end
    endtask

    task automatic test_reset_mid();
        logic        took, ro;
        logic [32:0] res;
        int          stale;
        step(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, took, res, ro);
        step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, took, res, ro);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || sum !== 32'd0 || cout !== 1'b0) begin
            errors++; $display("FAIL midrst_clear: got vld=%b sum=%h cout=%b expected 0/0/0", out_valid, sum, cout);
        end
        q32.delete();
`ifdef CSA_PIPE_OVF_EN
        qo32.delete();
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, took, res, ro);
            if (out_valid) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL midrst_stale: got %0d stale results expected 0", stale); end
    endtask

    task automatic test_random();
        logic        took, ro;
        logic [64:0] res, exp;
        logic [63:0] ra, rb;
        int          acc, cyc, sel;
        acc = 0; cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            sel = $urandom_range(0, 7);
            ra  = (sel == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            rb  = (sel == 1) ? 64'h0 : (sel == 2) ? 64'h7FFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0 && ir64) acc++;
            step64(ir64 ? iv64 | 1'b1 : 1'b1, ra, rb, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) != 0), took, res, ro);
            if (took) begin
                exp = (q64.size() > 0) ? q64.pop_front() : 65'h0;
                checks++; if (res !== exp) begin errors++; $display("FAIL rand_result: got %h expected %h", res, exp); end
`ifdef CSA_PIPE_OVF_EN
                if (qo64.size() > 0) begin
                    checks++; if (ro !== qo64[0]) begin errors++; $display("FAIL rand_ovf: got %b expected %b", ro, qo64[0]); end
                    void'(qo64.pop_front());
                end
`endif
            end
            cyc++;
            if ($urandom_range(0, 3) == 0) begin
                step64(1'b0, '0, '0, 1'b0, 1'b1, took, res, ro);
                if (took) begin
                    exp = (q64.size() > 0) ? q64.pop_front() : 65'h0;
                    checks++; if (res !== exp) begin errors++; $display("FAIL rand_result: got %h expected %h", res, exp); end
`ifdef CSA_PIPE_OVF_EN
                    if (qo64.size() > 0) begin
                        checks++; if (ro !== qo64[0]) begin errors++; $display("FAIL rand_ovf: got %b expected %b", ro, qo64[0]); end
                        void'(qo64.pop_front());
                    end
`endif
                end
                cyc++;
            end
        end
        cyc = 0;
        while (q64.size() > 0 && cyc < 20) begin
            step64(1'b0, '0, '0, 1'b0, 1'b1, took, res, ro);
            if (took) begin
                exp = q64.pop_front();
                checks++; if (res !== exp) begin errors++; $display("FAIL rand_drain: got %h expected %h", res, exp); end
`ifdef CSA_PIPE_OVF_EN
                if (qo64.size() > 0) void'(qo64.pop_front());
`endif
            end
            cyc++;
        end
        checks++; if (q64.size() !== 0) begin errors++; $display("FAIL rand_lost: got %0d pending expected 0", q64.size()); end
    endtask

    initial begin
        test_reset();
        test_single("basic",      32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        test_single("carry",      32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        test_single("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        test_single("mixed",      32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0, 1'b0);
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
